// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared fetch-stage types and constants (next-PC select, PC step)
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    typedef enum logic [2:0] {
        SEQ     = 3'd0,
        JUMP    = 3'd1,
        JUMPREG = 3'd2,
        BRANCH  = 3'd3,
        RETURN  = 3'd4
    } pcsel_t;

    localparam int PC_INCR = 4;

endpackage
`default_nettype wire

// File: rtl/pc_ras_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras_if
// Description : Fetch control / PC unit bundle (select, targets, PC and RAS view)
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_ras_if
    import cpu_types_pkg::*;
#(
    parameter int WIDTH = 32
);
    pcsel_t             pc_select;
    logic [WIDTH-1:0]   jump_data;
    logic               link;
    logic               stall;
    logic               flush;
    logic [WIDTH-1:0]   flush_addr;
    logic [WIDTH-1:0]   imem_addr;
    logic [WIDTH-1:0]   rtn_addr;
    logic [WIDTH-1:0]   ras_top;
    logic               ras_empty;
    logic               ras_full;

    modport master (
        output pc_select, jump_data, link, stall, flush, flush_addr,
        input  imem_addr, rtn_addr, ras_top, ras_empty, ras_full
    );

    modport slave (
        input  pc_select, jump_data, link, stall, flush, flush_addr,
        output imem_addr, rtn_addr, ras_top, ras_empty, ras_full
    );
endinterface
`default_nettype wire

// File: rtl/pc_ras_ras_stack.sv
`default_nettype none
// ============================================================================
// Module      : ras_stack
// Description : Circular return-address stack; overflow overwrites the oldest
// Revision    : 1.0 - initial release
// ============================================================================
module ras_stack #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  wire logic             CLK,
    input  wire logic             nRST,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic [WIDTH-1:0] push_data,
    output logic      [WIDTH-1:0] top,
    output logic                  empty,
    output logic                  full
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH) + 1;
    localparam logic [CW-1:0] c_FULL = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] r_mem [RAS_DEPTH];
    logic [PW-1:0]    r_top;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic [PW-1:0]    w_wr_idx;

    assign empty    = (r_count == '0);
    assign full     = (r_count == c_FULL);
    assign top      = empty ? '0 : r_mem[r_top];
    assign w_pop    = pop & ~empty;
    // A simultaneous pop+push rewrites the current top in place
    assign w_wr_idx = w_pop ? r_top : r_top + 1'b1;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (push && !w_pop) begin
            r_top <= r_top + 1'b1;
            if (!full) begin
                r_count <= r_count + 1'b1;
            end
        end else if (w_pop && !push) begin
            r_top   <= r_top - 1'b1;
            r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end
endmodule
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras
// Description : Fetch-stage PC with next-PC mux, redirect and return-address stack
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ras
    import cpu_types_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
    input  wire logic CLK,
    input  wire logic nRST,
    pc_ras_if.slave   bus
);
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_rtn;
    logic [WIDTH-1:0] w_jump;
    logic [WIDTH-1:0] w_branch;
    logic [WIDTH-1:0] w_top;
    logic             w_empty;
    logic             w_full;
    logic             w_active;
    logic             w_push;
    logic             w_pop;

    assign w_rtn    = r_pc + WIDTH'(PC_INCR);
    assign w_jump   = {r_pc[WIDTH-1:28], bus.jump_data[25:0], 2'b00};
    assign w_branch = w_rtn + {{(WIDTH-18){bus.jump_data[15]}}, bus.jump_data[15:0], 2'b00};

    // Stalled or redirected instructions must not disturb the call history
    assign w_active = ~bus.stall & ~bus.flush;
    assign w_push   = w_active & bus.link;
    assign w_pop    = w_active & (bus.pc_select == RETURN);

    always_comb begin
        w_next = w_rtn;
        if (bus.flush) begin
            w_next = bus.flush_addr;
        end else if (bus.stall) begin
            w_next = r_pc;
        end else begin
            case (bus.pc_select)
                SEQ:     w_next = w_rtn;
                JUMP:    w_next = w_jump;
                JUMPREG: w_next = bus.jump_data;
                BRANCH:  w_next = w_branch;
                RETURN:  w_next = w_empty ? bus.jump_data : w_top;
                default: w_next = w_rtn;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next;
        end
    end

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .CLK       (CLK),
        .nRST      (nRST),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_rtn),
        .top       (w_top),
        .empty     (w_empty),
        .full      (w_full)
    );

    assign bus.imem_addr = r_pc;
    assign bus.rtn_addr  = w_rtn;
    assign bus.ras_top   = w_top;
    assign bus.ras_empty = w_empty;
    assign bus.ras_full  = w_full;
endmodule
`default_nettype wire
